// File: rtl/rx_serial_7e1.sv
// -----------------------------------------------------------------------------
// rx_serial_7e1
//
// Receiver for 7E1 asynchronous serial frames: start bit (0), seven data bits
// LSB first, even parity bit, one stop bit (1). The line is resynchronised by
// two flops. Each bit is sampled once, near its middle, so glitches elsewhere
// in a bit are not seen.
//
// Parameters
//   M            clock cycles per bit period; must be even and >= 4
//
// Ports
//   clock        system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   dado_serial  asynchronous serial input, idle high
//   dados_ascii  last received character (bit 0 received first)
//   paridade_ok  1 when the last frame had even parity over data + parity
//   erro_stop    1 when the last frame's stop bit was sampled as 0
//   pronto       one-cycle pulse when a frame completes
//   db_estado    current FSM state code, for debug
// -----------------------------------------------------------------------------
module rx_serial_7e1 #(
    parameter int M = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    output logic [6:0] dados_ascii,
    output logic       paridade_ok,
    output logic       erro_stop,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        RECEBE = 4'd2,
        STOP   = 4'd3,
        FIM    = 4'd4
    } state_t;

    // The counter only needs to reach M-1.
    localparam int CW = $clog2(M);
    localparam logic [CW-1:0] LAST_HALF = CW'(M / 2 - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(M - 1);

    state_t        state;
    logic          sync_1;
    logic          s_rx;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;

    assign db_estado = state;

    // NOTE: every register below is assigned with <= so all of them update
    // together from the values present before the edge; the synchronizer only
    // works as two distinct stages because of this.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            // Resetting the synchronizer to the idle level prevents a
            // spurious start right after reset is released.
            sync_1      <= 1'b1;
            s_rx        <= 1'b1;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            dados_ascii <= '0;
            paridade_ok <= 1'b0;
            erro_stop   <= 1'b0;
            pronto      <= 1'b0;
        end else begin
            sync_1 <= dado_serial;
            s_rx   <= sync_1;
            pronto <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!s_rx) begin
                        state <= START;
                    end
                end

                // Wait half a bit so that every later sample lands mid-bit.
                START: begin
                    if (cnt == LAST_HALF) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= s_rx ? IDLE : RECEBE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Shift in from the top: after eight samples shift[6:0] holds
                // d6..d0 and shift[7] holds the parity bit.
                RECEBE: begin
                    if (cnt == LAST_BIT) begin
                        cnt     <= '0;
                        shift   <= {s_rx, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Results are registered on the edge that enters FIM, so they
                // are valid in the same cycle as the pronto pulse.
                STOP: begin
                    if (cnt == LAST_BIT) begin
                        cnt         <= '0;
                        state       <= FIM;
                        pronto      <= 1'b1;
                        dados_ascii <= shift[6:0];
                        paridade_ok <= ~(^shift);
                        erro_stop   <= ~s_rx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FIM: begin
                    cnt   <= '0;
                    state <= IDLE;
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_serial_7e1.sv
// -----------------------------------------------------------------------------
// tb_rx_serial_7e1
//
// Directed bench for rx_serial_7e1 with M = 8. The stimulus process pushes
// hand-computed expectations (character, parity flag, stop flag, edge of the
// pronto pulse) into a queue; an independent monitor pops one entry per
// pronto pulse and compares. Edges are numbered so that the edge sampling the
// start bit is edge 1 of its frame; pronto is expected at edge 79.
// -----------------------------------------------------------------------------
module tb_rx_serial_7e1;

    localparam int M       = 8;
    localparam int LATENCY = 78;   // edges after the start-sampling edge

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dado_serial = 1'b1;
    logic [6:0] dados_ascii;
    logic       paridade_ok;
    logic       erro_stop;
    logic       pronto;
    logic [3:0] db_estado;

    rx_serial_7e1 #(.M(M)) dut (
        .clock       (clock),
        .reset       (reset),
        .dado_serial (dado_serial),
        .dados_ascii (dados_ascii),
        .paridade_ok (paridade_ok),
        .erro_stop   (erro_stop),
        .pronto      (pronto),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] data;
        logic       par_ok;
        logic       err;
        int         edge_n;
    } exp_t;

    exp_t sb[$];
    int   edge_n           = 0;
    int   n_checks         = 0;
    int   n_fail           = 0;
    int   last_pronto_edge = -1;
    int   prev_pronto_edge = -1;
    logic prev_pronto      = 1'b0;

    always @(posedge clock) edge_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per pronto pulse.
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            check("pronto_single_cycle", {31'd0, prev_pronto}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pronto: pronto at edge %0d, no frame expected", edge_n);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dados_ascii", {25'd0, dados_ascii}, {25'd0, e.data});
                check("paridade_ok", {31'd0, paridade_ok}, {31'd0, e.par_ok});
                check("erro_stop",   {31'd0, erro_stop},   {31'd0, e.err});
                check("pronto_edge", edge_n, e.edge_n);
            end
            prev_pronto_edge = last_pronto_edge;
            last_pronto_edge = edge_n;
        end
        prev_pronto = pronto;
    end

    // Called and returns at a falling edge. abort_bit >= 0 asserts reset three
    // cycles into that bit (0 = start bit) instead of finishing the frame.
    task automatic send_frame(input logic [6:0] d, input logic p, input logic stp,
                              input logic exp_par, input logic exp_err, input int abort_bit);
        logic [9:0] bits;
        exp_t       e;
        bits     = {stp, p, d, 1'b0};
        e.data   = d;
        e.par_ok = exp_par;
        e.err    = exp_err;
        e.edge_n = edge_n + 1 + LATENCY;
        if (abort_bit < 0) sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            dado_serial = bits[i];
            if (i == abort_bit) begin
                repeat (3) @(negedge clock);
                reset       = 1'b1;
                dado_serial = 1'b1;
                @(negedge clock);
                check("abort_db_estado",   {28'd0, db_estado},   32'd0);
                check("abort_dados_ascii", {25'd0, dados_ascii}, 32'd0);
                check("abort_paridade_ok", {31'd0, paridade_ok}, 32'd0);
                check("abort_erro_stop",   {31'd0, erro_stop},   32'd0);
                check("abort_pronto",      {31'd0, pronto},      32'd0);
                reset = 1'b0;
                return;
            end
            repeat (M) @(negedge clock);
        end
    endtask

    task automatic idle(input int n);
        dado_serial = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic saw_start;
        logic back_idle;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_db_estado",   {28'd0, db_estado},   32'd0);
        check("reset_dados_ascii", {25'd0, dados_ascii}, 32'd0);
        check("reset_paridade_ok", {31'd0, paridade_ok}, 32'd0);
        check("reset_erro_stop",   {31'd0, erro_stop},   32'd0);
        check("reset_pronto",      {31'd0, pronto},      32'd0);
        reset = 1'b0;
        idle(4);

        // 'A' = 0x41: two ones, p=0 -> even.
        send_frame(7'h41, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(3 * M);

        // 0x43: three ones, p=0 -> odd parity.
        send_frame(7'h43, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle(3 * M);

        // False start: two low cycles only.
        dado_serial = 1'b0;
        repeat (2) @(negedge clock);
        dado_serial = 1'b1;
        saw_start = 1'b0;
        back_idle = 1'b0;
        for (int c = 0; c < 4 * M; c++) begin
            @(negedge clock);
            if (db_estado == 4'd1) saw_start = 1'b1;
            if (saw_start && db_estado == 4'd0) begin
                back_idle = 1'b1;
                break;
            end
        end
        check("false_start_enter",  {31'd0, saw_start}, 32'd1);
        check("false_start_return", {31'd0, back_idle}, 32'd1);
        check("false_start_dados",  {25'd0, dados_ascii}, 32'h43);
        check("false_start_par",    {31'd0, paridade_ok}, 32'd0);
        check("false_start_err",    {31'd0, erro_stop},   32'd0);
        idle(2 * M);

        // 0x55, p=0, stop bit 0 -> framing error flagged.
        send_frame(7'h55, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(3 * M);

        // Reset during data bit d3 (frame bit 4), then a clean 'A'.
        send_frame(7'h41, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        idle(2 * M);
        send_frame(7'h41, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(3 * M);

        // Back-to-back: 0x30 (p=0) then 0x7F (seven ones, p=1).
        send_frame(7'h30, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        send_frame(7'h7F, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        idle(3 * M);

        for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clock);
        check("all_frames_seen", sb.size(), 32'd0);
        check("back_to_back_spacing", last_pronto_edge - prev_pronto_edge, 32'd80);
        check("final_dados_ascii", {25'd0, dados_ascii}, 32'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
